// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN partial-sum datapath.
// Lane geometry and controller state encoding live here.
package cnn_pkg;

    localparam int LANES     = 32;
    localparam int LANE_LOG2 = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    // Low bit index of a lane within a packed lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_adder_tree.sv
// Combinational balanced adder tree reducing LANES signed lanes.
// All sums wrap modulo 2^WIDTH.
module psum_accum_ctrl_adder_tree
    import cnn_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]       sum
);

    for (genvar l = 0; l <= LANE_LOG2; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic [N*WIDTH-1:0] s;
        for (genvar i = 0; i < N; i++) begin : g_n
            if (l == 0) begin : g_leaf
                assign s[i*WIDTH +: WIDTH] =
                    in_data[lane_lo(i, WIDTH) +: WIDTH];
            end else begin : g_add
                assign s[i*WIDTH +: WIDTH] =
                    g_lvl[l-1].s[(2*i)*WIDTH +: WIDTH] +
                    g_lvl[l-1].s[(2*i+1)*WIDTH +: WIDTH];
            end
        end
    end

    assign sum = g_lvl[LANE_LOG2].s[WIDTH-1:0];

endmodule

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulator: bias + per-beat lane reductions over a job
// of len beats, presented on a valid/ready result port.
module psum_accum_ctrl
    import cnn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       cfg_len,
    input  logic [WIDTH-1:0]       cfg_bias,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] beat_sum;
    logic             in_fire;
    logic             out_fire;
    logic             last_beat;

    psum_accum_ctrl_adder_tree #(
        .WIDTH (WIDTH)
    ) u_adder_tree (
        .in_data (in_data),
        .sum     (beat_sum)
    );

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_beat = (cnt_q + CNT_W'(1)) == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (in_fire && last_beat) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_data = acc_q;
    assign done     = done_q;

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        done_d = 1'b0;
        if (state_q == ST_IDLE && start) begin
            // A zero-length job still consumes exactly one beat.
            len_d = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
            acc_d = cfg_bias;
            cnt_d = '0;
        end
        if (state_q == ST_ACCUM && in_fire) begin
            acc_d = acc_q + beat_sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == ST_OUTPUT && out_fire) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench for psum_accum_ctrl: directed jobs push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_psum_accum_ctrl;

    localparam int W  = 32;
    localparam int CW = 8;
    localparam int NL = 32;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [CW-1:0]   cfg_len;
    logic [W-1:0]    cfg_bias;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [NL*W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic            done;

    psum_accum_ctrl #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int done_cnt;
    int n_pop;
    int n_push;
    logic [W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(out_data), 64'hDEAD_BEEF_0000);
            end else begin
                chk("result", 64'(out_data), 64'(exp_q.pop_front()));
                n_pop++;
            end
        end
    end

    function automatic logic [NL*W-1:0] all_lanes(input logic [W-1:0] v);
        logic [NL*W-1:0] d;
        for (int i = 0; i < NL; i++) d[i*W +: W] = v;
        return d;
    endfunction

    function automatic logic [NL*W-1:0] lane_idx();
        logic [NL*W-1:0] d;
        for (int i = 0; i < NL; i++) d[i*W +: W] = W'(i);
        return d;
    endfunction

    function automatic logic [NL*W-1:0] lane0(input logic [W-1:0] v);
        logic [NL*W-1:0] d;
        d = '0;
        d[W-1:0] = v;
        return d;
    endfunction

    task automatic push(input logic [W-1:0] v);
        exp_q.push_back(v);
        n_push++;
    endtask

    task automatic start_job(input logic [CW-1:0] len,
                             input logic [W-1:0] bias);
        cfg_len  = len;
        cfg_bias = bias;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [NL*W-1:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("beat_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_hs();
        int n;
        n = 0;
        while (!(out_valid && out_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(out_valid && out_ready))
            chk("hs_timeout", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    int d0;

    initial begin
        n_chk = 0; n_fail = 0; done_cnt = 0; n_pop = 0; n_push = 0;
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_bias = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job: 10 + 32 + 64
        start_job(8'd2, 32'd10);
        push(32'd106);
        chk("basic_busy", 64'(busy), 64'd1);
        beat(all_lanes(32'd1));
        chk("basic_mid_valid", 64'(out_valid), 64'd0);
        chk("basic_acc_b0", 64'(out_data), 64'd42);
        beat(all_lanes(32'd2));
        chk("basic_latency", 64'(out_valid), 64'd1);
        chk("basic_in_ready_out", 64'(in_ready), 64'd0);
        d0 = done_cnt;
        wait_hs();
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_busy_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Signed wrap
        start_job(8'd1, 32'h7FFF_FFFF);
        push(32'h8000_0000);
        beat(lane0(32'd1));
        wait_hs();
        @(posedge clk); #1;

        // Gaps and backpressure: 100 + 32 + 96 + 496
        out_ready = 1'b0;
        start_job(8'd3, 32'd100);
        push(32'd724);
        beat(all_lanes(32'd1));
        in_data = all_lanes(32'd99);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("gap_acc_hold", 64'(out_data), 64'd132);
        end
        beat(all_lanes(32'd3));
        chk("gap_acc_b1", 64'(out_data), 64'd228);
        beat(lane_idx());
        d0 = done_cnt;
        in_valid = 1'b1;
        in_data  = all_lanes(32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'd724);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_hs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_one_done", 64'(done_cnt - d0), 64'd1);

        // len=0 behaves as one beat: -5 + 5
        out_ready = 1'b0;
        start_job(8'd0, 32'hFFFF_FFFB);
        push(32'd0);
        beat(lane0(32'd5));
        in_valid = 1'b1;
        in_data  = all_lanes(32'd7);
        chk("len0_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("len0_in_ready2", 64'(in_ready), 64'd0);
        chk("len0_data", 64'(out_data), 64'd0);
        chk("len0_valid", 64'(out_valid), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_hs();
        @(posedge clk); #1;

        // Mid-job reset, then a fresh job: 7 - 32
        start_job(8'd4, 32'd50);
        beat(all_lanes(32'd1));
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        chk("mrst_out_data", 64'(out_data), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = all_lanes(32'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst_no_resume", 64'(busy), 64'd0);
        in_valid = 1'b0;
        start_job(8'd1, 32'd7);
        push(32'hFFFF_FFE7);
        beat(all_lanes(32'hFFFF_FFFF));
        wait_hs();
        @(posedge clk); #1;

        // Back-to-back with start held high
        cfg_len  = 8'd2;
        cfg_bias = 32'd0;
        start    = 1'b1;
        @(posedge clk); #1;
        cfg_len  = 8'd1;
        cfg_bias = 32'd3;
        push(32'd64);
        push(32'd3);
        beat(all_lanes(32'd1));
        chk("b2b_ignore_start", 64'(out_valid), 64'd0);
        beat(all_lanes(32'd1));
        wait_hs();
        chk("b2b_done", 64'(done), 64'd1);
        chk("b2b_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("b2b_restart", 64'(busy), 64'd1);
        start = 1'b0;
        beat(all_lanes(32'd0));
        wait_hs();
        @(posedge clk); #1;

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("sb_pops", 64'(n_pop), 64'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_accum_ctrl.md
PSUM_ACCUM_CTRL -- requirements
Module: psum_accum_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the signed two's-complement width of each lane, the accumulator and the result.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the beat-count configuration.
REQ-003 The block SHALL use one clock, clk, and one asynchronous active-low reset, rst_n.
REQ-004 The ports SHALL be as follows:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  begin job; sampled only in IDLE
- cfg_len  in  CNT_W  beats per job
- cfg_bias  in  WIDTH  signed initial accumulator value
- busy  out  1  high when not IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- in_data  in  32*WIDTH  32 signed lanes; lane i at [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  WIDTH  signed result
- done  out  1  one-cycle pulse after the result handshake

Function
REQ-005 The block SHALL implement FSM states IDLE, ACCUM and OUTPUT.
REQ-006 In IDLE, when start=1, the block SHALL latch cfg_len into len_q, load acc with cfg_bias, clear the beat counter, and go to ACCUM on the next edge.
REQ-007 The block SHALL treat cfg_len=0 as len_q=1.
REQ-008 In ACCUM, in_ready SHALL be 1; in IDLE and OUTPUT, in_ready SHALL be 0.
REQ-009 On each accepted beat, the block SHALL update acc to acc + the sum of the 32 lanes, computed combinationally in the same cycle.
REQ-010 All sums SHALL be WIDTH bits and wrap modulo 2^WIDTH, with no saturation and no overflow flag.
REQ-011 The block SHALL increment the beat counter on each accepted beat; ACCUM cycles with in_valid=0 SHALL leave acc and the counter unchanged.
REQ-012 When the accepted beat is beat number len_q, the block SHALL go to OUTPUT, with out_valid=1 on the next cycle (latency of one cycle from the last beat to out_valid).
REQ-013 In OUTPUT, out_valid SHALL stay 1 and out_data SHALL stay equal to acc until out_ready=1.
REQ-014 On the output handshake, the block SHALL go to IDLE and assert done=1 for exactly the following cycle.
REQ-015 out_valid=1 with out_ready=1 in the first OUTPUT cycle SHALL give a zero-stall handshake.
REQ-016 start SHALL be ignored when not in IDLE.
REQ-017 start asserted in the same cycle that done is high SHALL start a new job, giving back-to-back jobs with one IDLE cycle.
REQ-018 in_valid, in_data and out_ready SHALL be ignored in states where the matching handshake is not enabled.
REQ-019 busy SHALL be 1 in ACCUM and OUTPUT, and 0 in IDLE.
REQ-020 out_data SHALL always equal acc, and is meaningful only while out_valid=1.

Reset
REQ-021 rst_n=0 SHALL, asynchronously and at any time including mid-job, force: state=IDLE, acc=0, counter=0, len_q=0, out_valid=0, done=0, in_ready=0, busy=0, out_data=0.
REQ-022 After rst_n deasserts, no partial job SHALL resume; a new start is required.

Structure
REQ-023 Lane count (32), FSM state encoding and the lane-slice helper constants SHALL live in the shared package cnn_pkg.
REQ-024 The 32-input reduction SHALL be the existing combinational adder-tree sub-module, instantiated once as u_adder_tree with WIDTH passed through.
REQ-025 The controller SHALL contain no other sub-modules, and all registers SHALL be clocked on the rising edge of clk.

Verification
REQ-026 Basic job: bias=10, len=2, beat0 all lanes=1, beat1 all lanes=2 -> out_data=106, out_valid 1 cycle after beat1, done pulse after the handshake.
REQ-027 Negative/wrap: WIDTH=32, bias=0x7FFFFFFF, len=1, lane0=1, others 0 -> out_data=0x80000000.
REQ-028 Gaps and backpressure: len=3 with in_valid gaps, out_ready held 0 for 5 cycles -> acc unchanged in gaps, out_data stable, one done only.
REQ-029 len=0: bias=-5, one beat with lanes summing to 5 -> out_data=0 after exactly one beat; a second beat is not accepted (in_ready=0).
REQ-030 Mid-job reset: rst_n pulsed low after 1 of 4 beats -> all outputs 0 immediately, busy=0, a subsequent job's result uses only the new bias and beats.
REQ-031 Back-to-back jobs: start held high across done -> second job starts one cycle after done; start pulses during ACCUM are ignored.
